// File: rtl/fpu_pkg.sv
// Shared FP32 field definitions, scheduler state type and the fdiv special-case fixup
// used by controllers that time-share an FPU datapath.
package fpu_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;

    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sched_state_t;

    // Returns {dz, quotient}; zero-exponent operands are treated as zero,
    // which the raw datapath does not handle.
    function automatic logic [32:0] fdiv_fixup(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic [31:0] res);
        logic s;
        s = x[SIGN_BIT] ^ y[SIGN_BIT];
        if (y[EXP_MSB:EXP_LSB] == '0)
            return {1'b1, (s ? NEG_INF : POS_INF)};
        if (x[EXP_MSB:EXP_LSB] == '0)
            return {1'b0, s, 31'd0};
        return {1'b0, res};
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found scanning upward from ptr+1, wrapping modulo N.
module rr_arb #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fdiv_sched.sv
// Round-robin scheduler sharing one fixed-latency fdiv datapath between N_REQ
// requesters; one operation in flight, result held until the owner consumes it.
module fdiv_sched
    import fpu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_x,
    input  logic [32*N_REQ-1:0]  req_y,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [31:0]          resp_data,
    output logic                 resp_dz,
    output logic [31:0]          div_x,
    output logic [31:0]          div_y,
    input  logic [31:0]          div_res
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    sched_state_t     state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [31:0]      x_q, x_d;
    logic [31:0]      y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_q, res_d;
    logic             dz_q, dz_d;

    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] grant_id;
    logic [31:0]      sel_x;
    logic [31:0]      sel_y;
    logic [32:0]      fixed;

    rr_arb #(.N(N_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_id = '0;
        sel_x    = '0;
        sel_y    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                grant_id = PTR_W'(i);
                sel_x    = req_x[32*i +: 32];
                sel_y    = req_y[32*i +: 32];
            end
        end
    end

    assign fixed = fdiv_fixup(x_q, y_q, div_res);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = grant_id;
                    ptr_d   = grant_id;
                    x_d     = sel_x;
                    y_d     = sel_y;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    res_d   = fixed[31:0];
                    dz_d    = fixed[32];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // Only the owner's consume matters; other resp_ready bits are ignored.
                if (resp_ready[owner_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(N_REQ - 1);
            owner_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    // Ready is gated by rst so every output reads zero while reset is held.
    assign req_ready  = (state_q == IDLE && !rst) ? grant : '0;
    assign resp_valid = (state_q == DONE) ? (N_REQ'(1) << owner_q) : '0;
    assign resp_data  = res_q;
    assign resp_dz    = dz_q;
    assign div_x      = (state_q == IDLE) ? 32'd0 : x_q;
    assign div_y      = (state_q == IDLE) ? 32'd0 : y_q;

endmodule
